// File: rtl/aes_sha3_ctrl_pkg.sv
// aes_sha3_ctrl_pkg: shared state encoding, default sizes and key-split
// positions for the password-keyed encrypt-and-MAC sequencer.
package aes_sha3_ctrl_pkg;

   // Default stream sizes in bytes
   localparam int DEF_SALT_BYTES = 16;
   localparam int DEF_PW_BYTES   = 15;
   localparam int DEF_MSG_BYTES  = 16;
   localparam int DEF_TAG_BYTES  = 32;

   // Split of the 256-bit derived key: upper half AES key, lower half MAC key
   localparam int AES_KEY_MSB = 255;
   localparam int AES_KEY_LSB = 128;
   localparam int MAC_KEY_MSB = 127;
   localparam int MAC_KEY_LSB = 0;

   // Output serialiser geometry (widest stream is the 32-byte tag)
   localparam int SER_W     = 256;
   localparam int SER_CNT_W = 6;

   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_LOAD_KEY = 4'd1,
      ST_KDF_RUN  = 4'd2,
      ST_WAIT_MSG = 4'd3,
      ST_LOAD_MSG = 4'd4,
      ST_AES_RUN  = 4'd5,
      ST_OUT_CT   = 4'd6,
      ST_MAC_RUN  = 4'd7,
      ST_OUT_TAG  = 4'd8,
      ST_DONE     = 4'd9
   } ctrl_state_e;

endpackage

// File: rtl/aes_sha3_byte_ser.sv
// aes_sha3_byte_ser: loads a word plus a byte count and emits the word
// LSB byte first, one byte per cycle, with a valid flag. The first byte is
// presented in the cycle right after the load edge so the owning state
// lasts exactly nbytes cycles. dout is zero whenever valid is low.
module aes_sha3_byte_ser
   import aes_sha3_ctrl_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load,
   input  logic [SER_W-1:0]     din,
   input  logic [SER_CNT_W-1:0] nbytes,
   output logic [7:0]           dout,
   output logic                 valid,
   output logic                 last
);

   logic [SER_W-1:0]     word_r;
   logic [SER_CNT_W-1:0] rem_r;
   logic [7:0]           dout_r;
   logic                 valid_r;

   // Shift the loaded word out byte by byte; clear everything once drained.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_r  <= '0;
         rem_r   <= '0;
         dout_r  <= 8'h00;
         valid_r <= 1'b0;
      end else if (load && (nbytes != '0)) begin
         word_r  <= {8'h00, din[SER_W-1:8]};
         dout_r  <= din[7:0];
         valid_r <= 1'b1;
         rem_r   <= nbytes - SER_CNT_W'(1);
      end else if (valid_r && (rem_r != '0)) begin
         word_r  <= {8'h00, word_r[SER_W-1:8]};
         dout_r  <= word_r[7:0];
         valid_r <= 1'b1;
         rem_r   <= rem_r - SER_CNT_W'(1);
      end else begin
         word_r  <= '0;
         dout_r  <= 8'h00;
         valid_r <= 1'b0;
         rem_r   <= '0;
      end
   end

   assign dout  = dout_r;
   assign valid = valid_r;
   assign last  = valid_r && (rem_r == '0);

endmodule

// File: rtl/aes_sha3_seq_ctrl.sv
// aes_sha3_seq_ctrl: top-level sequencer of the password-keyed
// encrypt-and-MAC engine. Collects salt+password, runs the KDF, collects the
// message, runs AES, streams the cipher, runs HMAC and streams the tag.
// Optional build macro CTRL_WDT_EN adds a per-wait watchdog that aborts to
// IDLE and raises a sticky o_err; without it waits are unbounded and o_err
// is tied low.
module aes_sha3_seq_ctrl
   import aes_sha3_ctrl_pkg::*;
#(
   parameter int SALT_BYTES = DEF_SALT_BYTES,
   parameter int PW_BYTES   = DEF_PW_BYTES,
   parameter int MSG_BYTES  = DEF_MSG_BYTES,
   parameter int TAG_BYTES  = DEF_TAG_BYTES,
   parameter int WDT_CYCLES = 4096
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [7:0]              i_data,
   input  logic                    i_start,
   input  logic                    i_mode,
   output logic [7:0]              o_data,
   output logic                    o_valid,
   output logic                    o_ien,
   output logic                    o_err,
   output logic                    kdf_start,
   output logic [8*SALT_BYTES-1:0] kdf_salt,
   output logic [8*PW_BYTES-1:0]   kdf_pw,
   input  logic                    kdf_done,
   input  logic [255:0]            kdf_key,
   output logic                    aes_start,
   output logic                    aes_mode,
   output logic [127:0]            aes_key,
   output logic [8*MSG_BYTES-1:0]  aes_din,
   input  logic                    aes_done,
   input  logic [8*MSG_BYTES-1:0]  aes_dout,
   output logic                    mac_start,
   output logic [127:0]            mac_key,
   output logic [8*MSG_BYTES-1:0]  mac_msg,
   input  logic                    mac_done,
   input  logic [8*TAG_BYTES-1:0]  mac_tag
);

   localparam int KEY_BYTES = SALT_BYTES + PW_BYTES;
   localparam int KEY_W     = 8 * KEY_BYTES;
   localparam int SALT_W    = 8 * SALT_BYTES;
   localparam int PW_W      = 8 * PW_BYTES;
   localparam int MSG_W     = 8 * MSG_BYTES;
   localparam int CNT_W     = $clog2(KEY_BYTES + 1);

   localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(KEY_BYTES - 1);
   localparam logic [CNT_W-1:0] MSG_LAST = CNT_W'(MSG_BYTES - 1);

   ctrl_state_e          state_r;
   ctrl_state_e          state_nxt_s;

   logic [KEY_W-1:0]     key_sr_r;
   logic [MSG_W-1:0]     msg_sr_r;
   logic [CNT_W-1:0]     cnt_r;
   logic [CNT_W-1:0]     cnt_inc_s;
   logic                 aes_mode_r;

   logic [127:0]         aes_key_r;
   logic [127:0]         mac_key_r;
   logic [MSG_W-1:0]     mac_msg_r;
   logic                 kdf_start_r;
   logic                 aes_start_r;
   logic                 mac_start_r;
   logic                 o_ien_r;

   logic                 kdf_ok_s;
   logic                 aes_ok_s;
   logic                 mac_ok_s;
   logic                 wdt_expire_s;

   logic                 ser_load_s;
   logic [SER_W-1:0]     ser_din_s;
   logic [SER_CNT_W-1:0] ser_n_s;
   logic [7:0]           ser_dout_s;
   logic                 ser_valid_s;
   logic                 ser_last_s;

   // Byte counter saturates at all-ones instead of wrapping.
   assign cnt_inc_s = (cnt_r == {CNT_W{1'b1}}) ? cnt_r : (cnt_r + CNT_W'(1));

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decode plus the accept strobes for done pulses and serialiser loads.
   always_comb begin
      state_nxt_s = state_r;
      kdf_ok_s    = 1'b0;
      aes_ok_s    = 1'b0;
      mac_ok_s    = 1'b0;
      ser_load_s  = 1'b0;
      ser_din_s   = '0;
      ser_n_s     = '0;
      case (state_r)
         ST_IDLE: begin
            if (i_start) begin
               state_nxt_s = ST_LOAD_KEY;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_LOAD_KEY: begin
            if (!i_start) begin
               state_nxt_s = ST_IDLE;
            end else if (cnt_r == KEY_LAST) begin
               state_nxt_s = ST_KDF_RUN;
            end else begin
               state_nxt_s = ST_LOAD_KEY;
            end
         end
         ST_KDF_RUN: begin
            if (kdf_done) begin
               kdf_ok_s    = 1'b1;
               state_nxt_s = ST_WAIT_MSG;
            end else if (wdt_expire_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_KDF_RUN;
            end
         end
         ST_WAIT_MSG: begin
            if (i_start) begin
               state_nxt_s = ST_LOAD_MSG;
            end else begin
               state_nxt_s = ST_WAIT_MSG;
            end
         end
         ST_LOAD_MSG: begin
            if (!i_start) begin
               state_nxt_s = ST_WAIT_MSG;
            end else if (cnt_r == MSG_LAST) begin
               state_nxt_s = ST_AES_RUN;
            end else begin
               state_nxt_s = ST_LOAD_MSG;
            end
         end
         ST_AES_RUN: begin
            if (aes_done) begin
               aes_ok_s    = 1'b1;
               ser_load_s  = 1'b1;
               ser_din_s   = {{(SER_W-MSG_W){1'b0}}, aes_dout};
               ser_n_s     = SER_CNT_W'(MSG_BYTES);
               state_nxt_s = ST_OUT_CT;
            end else if (wdt_expire_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_AES_RUN;
            end
         end
         ST_OUT_CT: begin
            if (ser_last_s) begin
               state_nxt_s = ST_MAC_RUN;
            end else begin
               state_nxt_s = ST_OUT_CT;
            end
         end
         ST_MAC_RUN: begin
            if (mac_done) begin
               mac_ok_s    = 1'b1;
               ser_load_s  = 1'b1;
               ser_din_s   = SER_W'(mac_tag);
               ser_n_s     = SER_CNT_W'(TAG_BYTES);
               state_nxt_s = ST_OUT_TAG;
            end else if (wdt_expire_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_MAC_RUN;
            end
         end
         ST_OUT_TAG: begin
            if (ser_last_s) begin
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_OUT_TAG;
            end
         end
         ST_DONE: begin
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Capture salt+password and message bytes MSB first; a dropped i_start discards the partial load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_sr_r   <= '0;
         msg_sr_r   <= '0;
         cnt_r      <= '0;
         aes_mode_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (i_start) begin
                  key_sr_r   <= {{(KEY_W-8){1'b0}}, i_data};
                  cnt_r      <= CNT_W'(1);
                  aes_mode_r <= i_mode;
               end else begin
                  cnt_r <= '0;
               end
            end
            ST_LOAD_KEY: begin
               if (i_start) begin
                  key_sr_r <= {key_sr_r[KEY_W-9:0], i_data};
                  cnt_r    <= cnt_inc_s;
               end else begin
                  key_sr_r <= '0;
                  cnt_r    <= '0;
               end
            end
            ST_WAIT_MSG: begin
               if (i_start) begin
                  msg_sr_r <= {{(MSG_W-8){1'b0}}, i_data};
                  cnt_r    <= CNT_W'(1);
               end else begin
                  cnt_r <= '0;
               end
            end
            ST_LOAD_MSG: begin
               if (i_start) begin
                  msg_sr_r <= {msg_sr_r[MSG_W-9:0], i_data};
                  cnt_r    <= cnt_inc_s;
               end else begin
                  msg_sr_r <= '0;
                  cnt_r    <= '0;
               end
            end
            default: begin
               cnt_r <= '0;
            end
         endcase
      end
   end

   // Latch core results, raise start pulses on entry to each wait state and register o_ien.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aes_key_r   <= '0;
         mac_key_r   <= '0;
         mac_msg_r   <= '0;
         kdf_start_r <= 1'b0;
         aes_start_r <= 1'b0;
         mac_start_r <= 1'b0;
         o_ien_r     <= 1'b0;
      end else begin
         if (kdf_ok_s) begin
            aes_key_r <= kdf_key[AES_KEY_MSB:AES_KEY_LSB];
            mac_key_r <= kdf_key[MAC_KEY_MSB:MAC_KEY_LSB];
         end
         if (aes_ok_s) begin
            mac_msg_r <= aes_dout;
         end
         kdf_start_r <= (state_nxt_s == ST_KDF_RUN) && (state_r != ST_KDF_RUN);
         aes_start_r <= (state_nxt_s == ST_AES_RUN) && (state_r != ST_AES_RUN);
         mac_start_r <= (state_nxt_s == ST_MAC_RUN) && (state_r != ST_MAC_RUN);
         o_ien_r     <= !((state_nxt_s == ST_IDLE) || (state_nxt_s == ST_WAIT_MSG));
      end
   end

`ifdef CTRL_WDT_EN
   localparam int WDT_W = (WDT_CYCLES > 2) ? $clog2(WDT_CYCLES) : 1;

   logic [WDT_W-1:0] wdt_cnt_r;
   logic             in_wait_s;
   logic             abort_s;
   logic             err_r;

   assign in_wait_s    = (state_r == ST_KDF_RUN) || (state_r == ST_AES_RUN) ||
                         (state_r == ST_MAC_RUN);
   assign wdt_expire_s = in_wait_s && (wdt_cnt_r == WDT_W'(WDT_CYCLES - 1));
   assign abort_s      = in_wait_s && (state_nxt_s == ST_IDLE);

   // Count cycles spent in the current core wait; restart on every state change.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wdt_cnt_r <= '0;
      end else if (in_wait_s && (state_nxt_s == state_r)) begin
         wdt_cnt_r <= wdt_cnt_r + WDT_W'(1);
      end else begin
         wdt_cnt_r <= '0;
      end
   end

   // Sticky abort flag, cleared when the first byte of a new key load is accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_r <= 1'b0;
      end else if (abort_s) begin
         err_r <= 1'b1;
      end else if ((state_r == ST_IDLE) && i_start) begin
         err_r <= 1'b0;
      end else begin
         err_r <= err_r;
      end
   end

   assign o_err = err_r;
`else
   assign wdt_expire_s = 1'b0;
   assign o_err        = 1'b0;
`endif

   aes_sha3_byte_ser u_ser (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (ser_load_s),
      .din    (ser_din_s),
      .nbytes (ser_n_s),
      .dout   (ser_dout_s),
      .valid  (ser_valid_s),
      .last   (ser_last_s)
   );

   assign o_data    = ser_dout_s;
   assign o_valid   = ser_valid_s;
   assign o_ien     = o_ien_r;
   assign kdf_start = kdf_start_r;
   assign kdf_salt  = key_sr_r[KEY_W-1 -: SALT_W];
   assign kdf_pw    = key_sr_r[PW_W-1:0];
   assign aes_start = aes_start_r;
   assign aes_mode  = aes_mode_r;
   assign aes_key   = aes_key_r;
   assign aes_din   = msg_sr_r;
   assign mac_start = mac_start_r;
   assign mac_key   = mac_key_r;
   assign mac_msg   = mac_msg_r;

endmodule

// File: tb/tb_aes_sha3_seq_ctrl.sv
// tb_aes_sha3_seq_ctrl: directed bench for the encrypt-and-MAC sequencer.
// The three crypto cores are modelled inline by the scenario tasks.
module tb_aes_sha3_seq_ctrl;

`ifdef CTRL_WDT_EN
   localparam int TB_WDT_CYCLES = 64;
`else
   localparam int TB_WDT_CYCLES = 4096;
`endif

   logic         clk = 1'b0;
   logic         rst_n;
   logic [7:0]   i_data;
   logic         i_start;
   logic         i_mode;
   logic [7:0]   o_data;
   logic         o_valid;
   logic         o_ien;
   logic         o_err;
   logic         kdf_start;
   logic [127:0] kdf_salt;
   logic [119:0] kdf_pw;
   logic         kdf_done;
   logic [255:0] kdf_key;
   logic         aes_start;
   logic         aes_mode;
   logic [127:0] aes_key;
   logic [127:0] aes_din;
   logic         aes_done;
   logic [127:0] aes_dout;
   logic         mac_start;
   logic [127:0] mac_key;
   logic [127:0] mac_msg;
   logic         mac_done;
   logic [255:0] mac_tag;

   int checks = 0;
   int errors = 0;

   logic [247:0] key1 = {128'h000102030405060708090a0b0c0d0e0f,
                         120'h414141000000000000000000000000};
   logic [247:0] key2 = {128'h808182838485868788898a8b8c8d8e8f,
                         120'h707172737475767778797a7b7c7d7e};
   logic [255:0] kk1  = {128'h2b7e151628aed2a6abf7158809cf4f3c,
                         128'hdeadbeef0011223344556677cafef00d};
   logic [127:0] msg1 = 128'h00112233445566778899aabbccddeeff;
   logic [127:0] ct1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   logic [255:0] tag1 = 256'h0102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f20;

   always #5 clk = ~clk;

   aes_sha3_seq_ctrl #(.WDT_CYCLES(TB_WDT_CYCLES)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_data    (i_data),
      .i_start   (i_start),
      .i_mode    (i_mode),
      .o_data    (o_data),
      .o_valid   (o_valid),
      .o_ien     (o_ien),
      .o_err     (o_err),
      .kdf_start (kdf_start),
      .kdf_salt  (kdf_salt),
      .kdf_pw    (kdf_pw),
      .kdf_done  (kdf_done),
      .kdf_key   (kdf_key),
      .aes_start (aes_start),
      .aes_mode  (aes_mode),
      .aes_key   (aes_key),
      .aes_din   (aes_din),
      .aes_done  (aes_done),
      .aes_dout  (aes_dout),
      .mac_start (mac_start),
      .mac_key   (mac_key),
      .mac_msg   (mac_msg),
      .mac_done  (mac_done),
      .mac_tag   (mac_tag)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic send_key(input logic [247:0] k, input int n);
      for (int i = 0; i < n; i++) begin
         i_start = 1'b1;
         i_data  = k[247-8*i -: 8];
         tick();
      end
      i_start = 1'b0;
      i_data  = 8'h00;
   endtask

   task automatic send_msg(input logic [127:0] m);
      for (int i = 0; i < 16; i++) begin
         i_start = 1'b1;
         i_data  = m[127-8*i -: 8];
         tick();
      end
      i_start = 1'b0;
      i_data  = 8'h00;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; i_data = 8'h00; i_start = 1'b0; i_mode = 1'b0;
      kdf_done = 1'b0; kdf_key = '0; aes_done = 1'b0; aes_dout = '0;
      mac_done = 1'b0; mac_tag = '0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({o_valid, o_ien, o_err, kdf_start, aes_start, mac_start, aes_mode} !== 7'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 0000000",
                  {o_valid, o_ien, o_err, kdf_start, aes_start, mac_start, aes_mode});
      end
      checks++;
      if ({o_data, aes_key, mac_key, mac_msg, kdf_salt, aes_din} !== '0) begin
         errors++;
         $display("FAIL reset_data: o_data=%h aes_key=%h mac_key=%h expected all zero",
                  o_data, aes_key, mac_key);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_key_load;
      send_key(key1, 31);
      checks++;
      if (kdf_start !== 1'b1) begin
         errors++; $display("FAIL kdf_start_pulse: got %b expected 1", kdf_start);
      end
      checks++;
      if (kdf_salt !== 128'h000102030405060708090a0b0c0d0e0f) begin
         errors++; $display("FAIL kdf_salt: got %h expected 000102030405060708090a0b0c0d0e0f", kdf_salt);
      end
      checks++;
      if (kdf_pw !== 120'h414141000000000000000000000000) begin
         errors++; $display("FAIL kdf_pw: got %h expected 414141000000000000000000000000", kdf_pw);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if ({kdf_start, o_ien} !== 2'b01) begin
            errors++; $display("FAIL kdf_wait_%0d: start/ien got %b expected 01", i, {kdf_start, o_ien});
         end
      end
      kdf_key  = kk1;
      kdf_done = 1'b1;
      tick();
      kdf_done = 1'b0;
      checks++;
      if (o_ien !== 1'b0) begin
         errors++; $display("FAIL ien_after_kdf: got %b expected 0", o_ien);
      end
      checks++;
      if ({aes_key, mac_key} !== {128'h2b7e151628aed2a6abf7158809cf4f3c,
                                  128'hdeadbeef0011223344556677cafef00d}) begin
         errors++; $display("FAIL key_split: aes_key=%h mac_key=%h", aes_key, mac_key);
      end
   endtask

   task automatic test_cipher_out;
      send_msg(msg1);
      checks++;
      if ({aes_start, aes_mode, o_ien} !== 3'b101) begin
         errors++; $display("FAIL aes_start: start/mode/ien got %b expected 101", {aes_start, aes_mode, o_ien});
      end
      checks++;
      if (aes_din !== 128'h00112233445566778899aabbccddeeff) begin
         errors++; $display("FAIL aes_din: got %h expected 00112233445566778899aabbccddeeff", aes_din);
      end
      tick();
      checks++;
      if (aes_start !== 1'b0) begin
         errors++; $display("FAIL aes_start_once: got %b expected 0", aes_start);
      end
      aes_dout = ct1;
      aes_done = 1'b1;
      tick();
      aes_done = 1'b0;
      aes_dout = '0;
      for (int i = 0; i < 16; i++) begin
         checks++;
         if ({o_valid, o_data} !== {1'b1, ct1[8*i +: 8]}) begin
            errors++; $display("FAIL ct_byte_%0d: valid/data got %b/%h expected 1/%h", i, o_valid, o_data, ct1[8*i +: 8]);
         end
         tick();
      end
      checks++;
      if ({o_valid, o_data, mac_start} !== {1'b0, 8'h00, 1'b1}) begin
         errors++; $display("FAIL ct_end: valid/data/mac_start got %b/%h/%b expected 0/00/1", o_valid, o_data, mac_start);
      end
      checks++;
      if (mac_msg !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin
         errors++; $display("FAIL mac_msg: got %h expected 69c4e0d86a7b0430d8cdb78070b4c55a", mac_msg);
      end
   endtask

   task automatic test_tag_out;
      tick();
      checks++;
      if ({o_valid, mac_start, o_ien} !== 3'b001) begin
         errors++; $display("FAIL mac_wait: valid/start/ien got %b expected 001", {o_valid, mac_start, o_ien});
      end
      mac_tag  = tag1;
      mac_done = 1'b1;
      tick();
      mac_done = 1'b0;
      for (int i = 0; i < 32; i++) begin
         checks++;
         if ({o_valid, o_data} !== {1'b1, 8'(32 - i)}) begin
            errors++; $display("FAIL tag_byte_%0d: valid/data got %b/%h expected 1/%h", i, o_valid, o_data, 8'(32 - i));
         end
         tick();
      end
      checks++;
      if ({o_valid, o_data, o_ien} !== {1'b0, 8'h00, 1'b1}) begin
         errors++; $display("FAIL done_state: valid/data/ien got %b/%h/%b expected 0/00/1", o_valid, o_data, o_ien);
      end
      tick();
      checks++;
      if (o_ien !== 1'b0) begin
         errors++; $display("FAIL idle_after_done: ien got %b expected 0", o_ien);
      end
   endtask

   task automatic test_abort_key;
      send_key(key2, 10);
      tick();
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({kdf_start, o_ien} !== 2'b00) begin
            errors++; $display("FAIL abort_idle_%0d: start/ien got %b expected 00", i, {kdf_start, o_ien});
         end
         tick();
      end
      checks++;
      if (kdf_salt !== 128'h0) begin
         errors++; $display("FAIL abort_discard: kdf_salt got %h expected 0", kdf_salt);
      end
      send_key(key2, 31);
      checks++;
      if ({kdf_start, kdf_salt, kdf_pw} !== {1'b1, key2}) begin
         errors++; $display("FAIL reload_key: start=%b salt=%h pw=%h", kdf_start, kdf_salt, kdf_pw);
      end
   endtask

   task automatic test_reset_mid;
      kdf_key  = kk1;
      kdf_done = 1'b1;
      tick();
      kdf_done = 1'b0;
      send_msg(msg1);
      aes_dout = ct1;
      aes_done = 1'b1;
      tick();
      aes_done = 1'b0;
      repeat (16) tick();
      mac_tag  = tag1;
      mac_done = 1'b1;
      tick();
      mac_done = 1'b0;
      repeat (7) tick();
      checks++;
      if ({o_valid, o_data} !== {1'b1, 8'h19}) begin
         errors++; $display("FAIL tag_byte7_pre: valid/data got %b/%h expected 1/19", o_valid, o_data);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({o_valid, o_data, o_ien, aes_key} !== {1'b0, 8'h00, 1'b0, 128'h0}) begin
         errors++; $display("FAIL async_reset: valid/data/ien got %b/%h/%b aes_key=%h expected 0/00/0/0",
                            o_valid, o_data, o_ien, aes_key);
      end
      #2;
      rst_n = 1'b1;
      i_mode = 1'b1;
      tick();
      send_key(key1, 31);
      i_mode = 1'b0;
      checks++;
      if ({kdf_start, aes_mode} !== 2'b11) begin
         errors++; $display("FAIL mode_latch: start/mode got %b expected 11", {kdf_start, aes_mode});
      end
      kdf_key  = kk1;
      kdf_done = 1'b1;
      tick();
      kdf_done = 1'b0;
      send_msg(msg1);
      checks++;
      if ({aes_start, aes_mode} !== 2'b11) begin
         errors++; $display("FAIL aes_mode_decrypt: start/mode got %b expected 11", {aes_start, aes_mode});
      end
   endtask

`ifdef CTRL_WDT_EN
   task automatic test_wdt;
      repeat (63) tick();
      checks++;
      if ({o_err, o_ien} !== 2'b01) begin
         errors++; $display("FAIL wdt_before: err/ien got %b expected 01", {o_err, o_ien});
      end
      tick();
      checks++;
      if ({o_err, o_ien} !== 2'b10) begin
         errors++; $display("FAIL wdt_abort: err/ien got %b expected 10", {o_err, o_ien});
      end
      i_start = 1'b1;
      i_data  = 8'h55;
      tick();
      i_start = 1'b0;
      checks++;
      if (o_err !== 1'b0) begin
         errors++; $display("FAIL wdt_clear: err got %b expected 0", o_err);
      end
      tick();
   endtask
`endif

   initial begin
      test_reset();
      test_key_load();
      test_cipher_out();
      test_tag_out();
      test_abort_key();
      test_reset_mid();
`ifdef CTRL_WDT_EN
      test_wdt();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
